// File: rtl/bfa_pkg.sv
// Shared types and sizing helpers for the bin frame averager and the upstream collector.
package bfa_pkg;

    localparam int BINS_DEF = 4;
    localparam int N_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    typedef logic [BINS_DEF-1:0][N_DEF-1:0] bin_vec_t;

    // Sum of 2**log2_frames samples of n bits, plus one bit of headroom for the rounding term.
    function automatic int acc_w(input int n, input int log2_frames);
        return n + log2_frames + 1;
    endfunction

endpackage

// File: rtl/bin_frame_averager_if.sv
// Frame-in / average-out bundle between the bin collector, the averager and the packetiser.
interface bin_frame_averager_if #(
    parameter int BINS = 4,
    parameter int N    = 16
);
    logic [BINS-1:0][N-1:0] in_bins;
    logic                   in_valid;
    logic                   clear;
    logic [BINS-1:0][N-1:0] out_avg;
    logic                   out_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        output in_bins, in_valid, clear,
        input  out_avg, out_valid, busy, overrun
    );

    modport slave (
        input  in_bins, in_valid, clear,
        output out_avg, out_valid, busy, overrun
    );
endinterface

// File: rtl/bfa_acc_bank.sv
// BINS x ACC_W accumulator bank: one indexed add/load port, parallel round-half-up read, sync clear.
module bfa_acc_bank
    import bfa_pkg::*;
#(
    parameter int BINS        = 4,
    parameter int N           = 16,
    parameter int LOG2_FRAMES = 4,
    parameter int IDX_W       = 2
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic                   wr_load,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [N-1:0]           wr_data,
    output logic [BINS-1:0][N-1:0] avg
);
    localparam int               ACC_W = acc_w(N, LOG2_FRAMES);
    localparam logic [ACC_W-1:0] HALF  = ACC_W'(1) << (LOG2_FRAMES - 1);

    logic [ACC_W-1:0] acc_r [BINS];

    // Accumulate or overwrite one bin per cycle; clear wins over a write.
    always_ff @(posedge clk) begin
        if (!areset_n || clr) begin
            for (int b = 0; b < BINS; b++) begin
                acc_r[b] <= {ACC_W{1'b0}};
            end
        end else if (wr_en) begin
            acc_r[wr_idx] <= wr_load ? ACC_W'(wr_data) : acc_r[wr_idx] + ACC_W'(wr_data);
        end
    end

    for (genvar b = 0; b < BINS; b++) begin : g_avg
        assign avg[b] = N'((acc_r[b] + HALF) >> LOG2_FRAMES);
    end

endmodule

// File: rtl/bin_frame_averager.sv
// Averages 2**LOG2_FRAMES consecutive BINS-wide frames per bin with a single serial adder.
module bin_frame_averager
    import bfa_pkg::*;
#(
    parameter int BINS        = 4,
    parameter int N           = 16,
    parameter int LOG2_FRAMES = 4
) (
    input  logic              clk,
    input  logic              areset_n,
    bin_frame_averager_if.slave bus
);
    localparam int                     IDX_W      = (BINS > 1) ? $clog2(BINS) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(BINS - 1);
    localparam logic [LOG2_FRAMES-1:0] LAST_FRAME = {LOG2_FRAMES{1'b1}};
    localparam logic [1:0]             S_IDLE     = IDLE;
    localparam logic [1:0]             S_ACCUM    = ACCUM;
    localparam logic [1:0]             S_DUMP     = DUMP;

    logic [1:0]             state_r;
    logic [BINS-1:0][N-1:0] frame_r;
    logic [IDX_W-1:0]       bin_idx_r;
    logic [LOG2_FRAMES-1:0] frame_cnt_r;
    logic [BINS-1:0][N-1:0] out_avg_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic                   overrun_r;
    logic                   acc_wr_s;
    logic                   acc_load_s;
    logic                   acc_clr_s;
    logic [BINS-1:0][N-1:0] avg_s;

    // Serial adder control; the first frame of a window overwrites instead of adding.
    always_comb begin
        acc_wr_s   = 1'b0;
        acc_load_s = 1'b0;
        acc_clr_s  = bus.clear || (state_r == S_DUMP);
        if ((state_r == S_ACCUM) && !bus.clear) begin
            acc_wr_s   = 1'b1;
            acc_load_s = (frame_cnt_r == {LOG2_FRAMES{1'b0}});
        end else begin
            acc_wr_s   = 1'b0;
            acc_load_s = 1'b0;
        end
    end

    bfa_acc_bank #(
        .BINS        (BINS),
        .N           (N),
        .LOG2_FRAMES (LOG2_FRAMES),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (acc_clr_s),
        .wr_en    (acc_wr_s),
        .wr_load  (acc_load_s),
        .wr_idx   (bin_idx_r),
        .wr_data  (frame_r[bin_idx_r]),
        .avg      (avg_s)
    );

    // Window FSM, counters, registered outputs and sticky overrun.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state_r     <= S_IDLE;
            frame_r     <= '0;
            bin_idx_r   <= {IDX_W{1'b0}};
            frame_cnt_r <= {LOG2_FRAMES{1'b0}};
            out_avg_r   <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (bus.clear) begin
            state_r     <= S_IDLE;
            bin_idx_r   <= {IDX_W{1'b0}};
            frame_cnt_r <= {LOG2_FRAMES{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (bus.in_valid && (state_r != S_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        frame_r   <= bus.in_bins;
                        bin_idx_r <= {IDX_W{1'b0}};
                        state_r   <= S_ACCUM;
                        busy_r    <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (bin_idx_r == LAST_IDX) begin
                        bin_idx_r <= {IDX_W{1'b0}};
                        if (frame_cnt_r == LAST_FRAME) begin
                            state_r <= S_DUMP;
                        end else begin
                            frame_cnt_r <= frame_cnt_r + LOG2_FRAMES'(1);
                            state_r     <= S_IDLE;
                            busy_r      <= 1'b0;
                        end
                    end else begin
                        bin_idx_r <= bin_idx_r + IDX_W'(1);
                    end
                end
                S_DUMP: begin
                    out_avg_r   <= avg_s;
                    out_valid_r <= 1'b1;
                    frame_cnt_r <= {LOG2_FRAMES{1'b0}};
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_avg   = out_avg_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_bin_frame_averager.sv
// Randomised self-checking bench for bin_frame_averager against a plain-arithmetic mean model.
module tb_bin_frame_averager;
    localparam int BINS = 4;
    localparam int N    = 16;
    typedef logic [BINS-1:0][N-1:0] frame_t;

    logic clk      = 1'b0;
    logic areset_n = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   ov_cnt   = 0;
    int   ov8_cnt  = 0;
    frame_t last_exp;

    always #5 clk = ~clk;

    bin_frame_averager_if #(.BINS(BINS), .N(N)) bif ();
    bin_frame_averager_if #(.BINS(BINS), .N(N)) bif8 ();

    bin_frame_averager #(.BINS(BINS), .N(N), .LOG2_FRAMES(2)) dut (
        .clk(clk), .areset_n(areset_n), .bus(bif));
    bin_frame_averager #(.BINS(BINS), .N(N), .LOG2_FRAMES(8)) dut8 (
        .clk(clk), .areset_n(areset_n), .bus(bif8));

    always @(posedge clk) begin
        #1;
        if (bif.out_valid === 1'b1) ov_cnt++;
        if (bif8.out_valid === 1'b1) ov8_cnt++;
    end

    // Reference: rounded mean = floor((sum + 2**(l2-1)) / 2**l2).
    function automatic frame_t ref_mean(input longint sums [BINS], input int l2);
        frame_t r;
        for (int b = 0; b < BINS; b++) begin
            r[b] = N'((sums[b] + (longint'(1) << (l2 - 1))) / (longint'(1) << l2));
        end
        return r;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int b = 0; b < BINS; b++) begin
            f[b] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : N'($urandom);
        end
        return f;
    endfunction

    task automatic send(input frame_t f);
        bif.in_bins  = f;
        bif.in_valid = 1'b1;
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic send8(input frame_t f);
        bif8.in_bins  = f;
        bif8.in_valid = 1'b1;
        @(negedge clk);
        bif8.in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out(input bit sel8, output int lat);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if ((sel8 ? bif8.out_valid : bif.out_valid) === 1'b1) lat = k;
        end
    endtask

    task automatic pulse_reset();
        areset_n = 1'b0;
        gap(1);
        areset_n = 1'b1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        gap(3);
        n_cmp++; if (bif.out_avg !== '0) begin n_bad++; $display("FAIL reset_out_avg: got %h want 0", bif.out_avg); end
        n_cmp++; if (bif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
        n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
        n_cmp++; if (bif.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", bif.overrun); end
        n_cmp++; if (bif8.out_avg !== '0 || bif8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_l8: got avg %h busy %b want 0/0", bif8.out_avg, bif8.busy); end
        areset_n = 1'b1;
        gap(1);
    endtask

    task automatic test_basic();
        frame_t f;
        longint sums [BINS];
        int lat;
        int ov0;
        f = {16'd4, 16'd3, 16'd2, 16'd1};
        for (int b = 0; b < BINS; b++) sums[b] = 0;
        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) begin
            send(f);
            for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
            if (i < 3) gap(7);
        end
        n_cmp++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_during: got %b want 1", bif.busy); end
        wait_out(1'b0, lat);
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_cmp++; if (bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL basic_out_avg: got %h want %h", bif.out_avg, ref_mean(sums, 2)); end
        n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", bif.busy); end
        gap(3);
        n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL basic_valid_count: got %0d want 1", ov_cnt - ov0); end
    endtask

    task automatic test_rounding();
        frame_t f;
        longint sums [BINS];
        int lat;
        for (int b = 0; b < BINS; b++) sums[b] = 0;
        for (int i = 0; i < 4; i++) begin
            f = rand_frame();
            f[0] = N'(i);
            f[1] = (i == 3) ? 16'd1 : 16'd0;
            for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
            send(f);
            if (i < 3) gap(6);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (bif.out_avg[0] !== 16'd2) begin n_bad++; $display("FAIL round_bin0: got %0d want 2", bif.out_avg[0]); end
        n_cmp++; if (bif.out_avg[1] !== 16'd0) begin n_bad++; $display("FAIL round_bin1: got %0d want 0", bif.out_avg[1]); end
        n_cmp++; if (bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL round_all: got %h want %h", bif.out_avg, ref_mean(sums, 2)); end
    endtask

    task automatic test_max();
        frame_t f;
        int lat;
        f = {BINS{16'hFFFF}};
        for (int i = 0; i < 4; i++) begin
            send(f);
            if (i < 3) gap(5);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (lat < 0 || bif.out_avg !== f) begin n_bad++; $display("FAIL max_l2: got %h (lat %0d) want %h", bif.out_avg, lat, f); end
        for (int i = 0; i < 256; i++) begin
            send8(f);
            if (i < 255) gap(5);
        end
        wait_out(1'b1, lat);
        n_cmp++; if (lat != 5 || bif8.out_avg !== f) begin n_bad++; $display("FAIL max_l8: got %h (lat %0d) want %h lat 5", bif8.out_avg, lat, f); end
        n_cmp++; if (ov8_cnt != 1) begin n_bad++; $display("FAIL max_l8_count: got %0d want 1", ov8_cnt); end
    endtask

    task automatic test_overrun();
        frame_t f;
        longint sums [BINS];
        int lat;
        int ov0;
        ov0 = ov_cnt;
        n_cmp++; if (bif.overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_pre: got %b want 0", bif.overrun); end
        f = rand_frame();
        for (int b = 0; b < BINS; b++) sums[b] = longint'(f[b]);
        send(f);
        gap(1);
        send(rand_frame());
        n_cmp++; if (bif.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", bif.overrun); end
        gap(6);
        for (int i = 0; i < 3; i++) begin
            f = rand_frame();
            for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
            send(f);
            if (i < 2) gap(7);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (lat != 5 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL overrun_avg: got %h (lat %0d) want %h", bif.out_avg, lat, ref_mean(sums, 2)); end
        gap(2);
        n_cmp++; if (bif.overrun !== 1'b1 || ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL overrun_sticky: got ovr %b count %0d want 1/1", bif.overrun, ov_cnt - ov0); end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        longint sums [BINS];
        int lat;
        int ov0;
        ov0 = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            send({BINS{16'd9}});
            if (i < 2) gap(7);
        end
        gap(1);
        pulse_reset();
        n_cmp++; if (bif.out_avg !== '0 || bif.busy !== 1'b0 || bif.out_valid !== 1'b0 || bif.overrun !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs: got avg %h busy %b valid %b ovr %b want all 0", bif.out_avg, bif.busy, bif.out_valid, bif.overrun); end
        gap(2);
        f = {BINS{16'd5}};
        for (int b = 0; b < BINS; b++) sums[b] = 4 * longint'(f[b]);
        for (int i = 0; i < 4; i++) begin
            send(f);
            if (i < 3) gap(7);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (lat != 5 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL midreset_avg: got %h (lat %0d) want %h", bif.out_avg, lat, ref_mean(sums, 2)); end
        gap(2);
        n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL midreset_count: got %0d want 1", ov_cnt - ov0); end
        last_exp = ref_mean(sums, 2);
    endtask

    task automatic test_clear();
        frame_t f;
        longint sums [BINS];
        int lat;
        int ov0;
        ov0 = ov_cnt;
        send({BINS{16'd8}});
        gap(7);
        send({BINS{16'd8}});
        gap(1);
        bif.clear = 1'b1;
        gap(1);
        bif.clear = 1'b0;
        n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy: got %b want 0", bif.busy); end
        n_cmp++; if (bif.out_avg !== last_exp) begin n_bad++; $display("FAIL clear_hold: got %h want %h", bif.out_avg, last_exp); end
        gap(3);
        f = {BINS{16'd4}};
        for (int b = 0; b < BINS; b++) sums[b] = 4 * longint'(f[b]);
        for (int i = 0; i < 4; i++) begin
            send(f);
            if (i < 3) gap(7);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (lat != 5 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL clear_avg: got %h (lat %0d) want %h", bif.out_avg, lat, ref_mean(sums, 2)); end
        gap(2);
        n_cmp++; if (ov_cnt - ov0 != 1) begin n_bad++; $display("FAIL clear_count: got %0d want 1", ov_cnt - ov0); end
    endtask

    task automatic test_random();
        frame_t f;
        longint sums [BINS];
        int lat;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < BINS; b++) sums[b] = 0;
            for (int i = 0; i < 4; i++) begin
                f = rand_frame();
                for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
                send(f);
                if (i < 3) gap($urandom_range(5, 9));
            end
            wait_out(1'b0, lat);
            n_cmp++; if (lat != 5 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL random_w%0d: got %h (lat %0d) want %h", w, bif.out_avg, lat, ref_mean(sums, 2)); end
            gap($urandom_range(1, 4));
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        longint sums [BINS];
        int lat;
        pulse_reset();
        for (int b = 0; b < BINS; b++) sums[b] = 0;
        for (int i = 0; i < 4; i++) begin
            f = rand_frame();
            for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
            send(f);
            gap(4);
        end
        n_cmp++; if (bif.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_min_gap: got overrun %b want 0", bif.overrun); end
        send(rand_frame());
        n_cmp++; if (bif.out_valid !== 1'b1 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL b2b_avg: got valid %b avg %h want 1 %h", bif.out_valid, bif.out_avg, ref_mean(sums, 2)); end
        n_cmp++; if (bif.overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_dump_drop: got overrun %b want 1", bif.overrun); end
        for (int b = 0; b < BINS; b++) sums[b] = 0;
        for (int i = 0; i < 4; i++) begin
            f = rand_frame();
            for (int b = 0; b < BINS; b++) sums[b] += longint'(f[b]);
            send(f);
            if (i < 3) gap(5);
        end
        wait_out(1'b0, lat);
        n_cmp++; if (lat != 5 || bif.out_avg !== ref_mean(sums, 2)) begin n_bad++; $display("FAIL b2b_next_window: got %h (lat %0d) want %h", bif.out_avg, lat, ref_mean(sums, 2)); end
    endtask

    initial begin
        bif.in_bins   = '0;
        bif.in_valid  = 1'b0;
        bif.clear     = 1'b0;
        bif8.in_bins  = '0;
        bif8.in_valid = 1'b0;
        bif8.clear    = 1'b0;
        last_exp      = '0;
        test_reset();
        test_basic();
        test_rounding();
        test_max();
        test_overrun();
        test_reset_mid();
        test_clear();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
